loop_ctrl: RTL and testbench
============================

LOOP_CTRL -- requirements
Module: loop_ctrl

Interface
REQ-001 Parameter: W, 4, width of trip-count bound and iteration index.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  launch request; sampled only in IDLE.
REQ-005 bound  input  W  trip count; captured on the accepted start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 iter_valid  output  1  iteration index offered to the loop body.
REQ-008 iter_ready  input  1  loop body accepts the offered index.
REQ-009 iter_idx  output  W  current iteration index, 0..bound-1.
REQ-010 done  output  1  one-cycle pulse on loop completion.

Function
REQ-011 The FSM SHALL have states IDLE, INIT, ISSUE and FINISH, held in a registered state variable.
REQ-012 IDLE with start=1 SHALL go to INIT on the next edge and latch bound into bound_q.
REQ-013 IDLE with start=0 SHALL remain in IDLE.
REQ-014 INIT SHALL load iter_idx=0.
REQ-015 INIT SHALL go to FINISH if bound_q==0, else to ISSUE.
REQ-016 iter_valid SHALL be high exactly while in ISSUE; iter_idx SHALL be stable while iter_valid=1 and iter_ready=0.
REQ-017 In ISSUE, a handshake (iter_valid & iter_ready) with iter_idx==bound_q-1 SHALL go to FINISH without incrementing iter_idx.
REQ-018 In ISSUE, any other handshake SHALL increment iter_idx by 1 and stay in ISSUE.
REQ-019 iter_idx SHALL never wrap: bound=2^W-1 SHALL issue indices 0..2^W-2 only.
REQ-020 done SHALL be high exactly in FINISH, one cycle only, followed unconditionally by IDLE.
REQ-021 start SHALL be ignored outside IDLE, including in the FINISH cycle; bound changes after capture SHALL have no effect.
REQ-022 With iter_ready held high, done SHALL assert bound+2 cycles after the start cycle (start at cycle 0: INIT at cycle 1, first index at cycle 2).
REQ-023 Each stall cycle (iter_ready=0 in ISSUE) SHALL add exactly one cycle of latency.

Reset
REQ-024 reset=1 SHALL force, asynchronously: state=IDLE, iter_idx=0, bound_q=0, done=0, iter_valid=0, busy=0.
REQ-025 Reset asserted mid-loop SHALL abort the loop; no done pulse SHALL be produced for the aborted run.
REQ-026 After reset deasserts, the block SHALL accept start on the first clock edge.

Structure
REQ-027 The state enum type SHALL be defined in the shared package loop_pkg, together with the default W constant.
REQ-028 The block SHALL be a single module with no sub-modules; the index counter SHALL be an inline registered counter.

Verification
REQ-029 W=4, bound=3, iter_ready=1, start pulsed at cycle 0 -> iter_idx 0,1,2 on cycles 2,3,4; done=1 only at cycle 5; busy high on cycles 1-5.
REQ-030 bound=0, start at cycle 0 -> iter_valid never asserts; done=1 at cycle 2; IDLE at cycle 3.
REQ-031 bound=2, iter_ready low for 3 cycles while iter_idx=0 -> iter_idx held at 0 with iter_valid=1 throughout the stall; done at cycle 7.
REQ-032 bound=15 (W=4), iter_ready=1 -> exactly 15 handshakes, last iter_idx=14, no wrap; done at cycle 17.
REQ-033 start held high continuously with bound=1 -> runs back-to-back; done at cycles 3 and 7; start is ignored while busy.
REQ-034 reset asserted at cycle 3 of a bound=5 run -> outputs clear immediately without waiting for a clock edge; no done pulse; a fresh start at cycle 6 with bound=2 -> done at cycle 10.

Source files
------------

// File: rtl/loop_pkg.sv
// Shared definitions for the counted-loop sequencer: default index width and FSM state encoding.
package loop_pkg;

    localparam int LOOP_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        ISSUE  = 2'd2,
        FINISH = 2'd3
    } loop_state_e;

endpackage

// File: rtl/loop_ctrl.sv
// Counted-loop sequencer: captures a trip count, hands out indices 0..bound-1 over a
// valid/ready handshake, then pulses done for one cycle.
module loop_ctrl
    import loop_pkg::*;
#(
    parameter int W = LOOP_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bound,
    output logic         busy,
    output logic         iter_valid,
    input  logic         iter_ready,
    output logic [W-1:0] iter_idx,
    output logic         done
);

    loop_state_e  state;
    logic [W-1:0] bound_q;
    logic         last_idx;

    // Compare against bound_q-1 rather than incrementing past it, so the index never wraps.
    assign last_idx = (iter_idx == W'(bound_q - W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bound_q    <= '0;
            iter_idx   <= '0;
            busy       <= 1'b0;
            iter_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= INIT;
                        bound_q <= bound;
                        busy    <= 1'b1;
                    end
                end
                INIT: begin
                    iter_idx <= '0;
                    if (bound_q == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state      <= ISSUE;
                        iter_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (iter_ready) begin
                        if (last_idx) begin
                            state      <= FINISH;
                            iter_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            iter_idx <= iter_idx + W'(1);
                        end
                    end
                end
                FINISH: begin
                    // start is deliberately not looked at here; a new run needs an IDLE cycle.
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    iter_valid <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_ctrl.sv
// Directed bench for loop_ctrl: cycle-accurate checks of issue order, stalls, back-to-back
// starts, the full-range bound and asynchronous abort.
module tb_loop_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] bound;
    logic         busy;
    logic         iter_valid;
    logic         iter_ready;
    logic [W-1:0] iter_idx;
    logic         done;

    int total = 0;
    int bad   = 0;

    loop_ctrl #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bound      (bound),
        .busy       (busy),
        .iter_valid (iter_valid),
        .iter_ready (iter_ready),
        .iter_idx   (iter_idx),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs, last, max_idx, done_cyc;

        reset = 1'b1; start = 1'b0; bound = '0; iter_ready = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", iter_valid, 0);
        chk("rst_idx", iter_idx, 0);
        chk("rst_done", done, 0);
        step(); step();
        reset = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // bound=3, ready held high
        start = 1'b1; bound = 4'd3; iter_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0; bound = 4'd9;
            chk($sformatf("b3_valid_c%0d", c), iter_valid, (c >= 2 && c <= 4));
            if (c >= 2 && c <= 4) chk($sformatf("b3_idx_c%0d", c), iter_idx, c - 2);
            chk($sformatf("b3_done_c%0d", c), done, (c == 5));
            chk($sformatf("b3_busy_c%0d", c), busy, (c >= 1 && c <= 5));
        end

        // bound=0: straight to FINISH
        start = 1'b1; bound = 4'd0;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            chk($sformatf("b0_valid_c%0d", c), iter_valid, 0);
            chk($sformatf("b0_done_c%0d", c), done, (c == 2));
            chk($sformatf("b0_busy_c%0d", c), busy, (c <= 2));
        end

        // bound=2 with a 3-cycle stall on index 0
        start = 1'b1; bound = 4'd2; iter_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            start = 1'b0;
            iter_ready = !(c >= 2 && c <= 4);
            if (c >= 2 && c <= 6) begin
                chk($sformatf("st_valid_c%0d", c), iter_valid, 1);
                chk($sformatf("st_idx_c%0d", c), iter_idx, (c == 6) ? 1 : 0);
            end
            chk($sformatf("st_done_c%0d", c), done, (c == 7));
        end
        iter_ready = 1'b1;

        // bound=15: full index range without wrap
        start = 1'b1; bound = 4'd15;
        hs = 0; last = -1; max_idx = 0; done_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            start = 1'b0;
            if (iter_valid && iter_ready) begin
                hs++;
                last = int'(iter_idx);
                if (int'(iter_idx) > max_idx) max_idx = int'(iter_idx);
            end
            if (done && done_cyc < 0) done_cyc = c;
        end
        chk("b15_handshakes", hs, 15);
        chk("b15_last_idx", last, 14);
        chk("b15_max_idx", max_idx, 14);
        chk("b15_done_cycle", done_cyc, 17);

        // start held high, bound=1: back-to-back runs, FINISH ignores start
        start = 1'b1; bound = 4'd1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) start = 1'b0;
            chk($sformatf("b2b_done_c%0d", c), done, (c == 3 || c == 7));
            chk($sformatf("b2b_busy_c%0d", c), busy, (c != 4 && c != 8));
        end

        // bound=5 run aborted by reset in cycle 3
        start = 1'b1; bound = 4'd5;
        step(); start = 1'b0;
        step(); step();
        chk("ab_pre_valid", iter_valid, 1);
        chk("ab_pre_idx", iter_idx, 1);
        reset = 1'b1;
        #1;
        chk("ab_async_busy", busy, 0);
        chk("ab_async_valid", iter_valid, 0);
        chk("ab_async_idx", iter_idx, 0);
        chk("ab_async_done", done, 0);
        step(); chk("ab_done_c4", done, 0);
        step(); chk("ab_done_c5", done, 0);
        step();
        reset = 1'b0; start = 1'b1; bound = 4'd2;
        for (int c = 7; c <= 11; c++) begin
            step();
            start = 1'b0;
            chk($sformatf("rs_done_c%0d", c), done, (c == 10));
            chk($sformatf("rs_busy_c%0d", c), busy, (c <= 10));
            if (c == 8 || c == 9) chk($sformatf("rs_idx_c%0d", c), iter_idx, c - 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
